cntrl_pulse_sequencer_multi: RTL and testbench

- Byte-serial command decoder driving N_CHAN independent pulse generators.
- Each generator has programmable initial level, initial delay, high time and low time.
- Successor to the single-channel sequencer controller, with these additions:
  - channel addressing, plus a broadcast address;
  - a per-write register-select mask;
  - a parametrised count width;
  - an error flag for bad addresses.
- Sits between the host command demultiplexer (mask_bit/cmd_data) and the output pins.

---
 rtl/cntrl_pulse_sequencer_multi.sv | 124 ++++++++++++
 tb/tb_cntrl_pulse_sequencer_multi.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cntrl_pulse_sequencer_multi.sv
// Byte-serial command decoder feeding N_CHAN independent programmable pulse generators.
// Header byte selects channel (0xF = all) and registers; value follows MSB byte first.
module cntrl_pulse_sequencer_multi #(
  parameter int N_CHAN      = 4,
  parameter int COUNT_WIDTH = 32,
  localparam int NBYTES     = COUNT_WIDTH / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              operate,
  input  logic              mask_bit,
  input  logic [7:0]        cmd_data,
  output logic              data_ack,
  output logic              cmd_err,
  output logic [N_CHAN-1:0] out
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_COMMIT} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             byte_q, byte_d;
  logic [7:0]             hdr_q, hdr_d;
  logic [COUNT_WIDTH-1:0] value_q, value_d;
  logic                   err_q, err_d;
  logic                   idx_bcast;
  logic                   idx_legal;
  logic                   commit;

  assign idx_bcast = (hdr_q[3:0] == 4'hF);
  assign idx_legal = idx_bcast || (int'(hdr_q[3:0]) < N_CHAN);
  assign commit    = (state_q == S_COMMIT) && idx_legal;
  assign data_ack  = (state_q != S_IDLE);
  assign cmd_err   = err_q;

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    hdr_d   = hdr_q;
    value_d = value_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (mask_bit) state_d = S_HDR;
      end
      S_HDR: begin
        hdr_d   = cmd_data;
        byte_d  = 3'd0;
        state_d = S_DATA;
      end
      S_DATA: begin
        value_d = (value_q << 8) | COUNT_WIDTH'(cmd_data);
        if (byte_q == 3'(NBYTES - 1)) state_d = S_COMMIT;
        else                          byte_d  = byte_q + 3'd1;
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        if (!idx_legal) err_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      byte_q  <= 3'd0;
      hdr_q   <= 8'd0;
      value_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      hdr_q   <= hdr_d;
      value_q <= value_d;
      err_q   <= err_d;
    end
  end

  for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_chan
    logic                   hit;
    logic                   init_state_q;
    logic [COUNT_WIDTH-1:0] init_count_q, hi_count_q, lo_count_q;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   out_q, out_d;

    assign hit     = commit && (idx_bcast || (hdr_q[3:0] == 4'(gi)));
    assign out[gi] = out_q;

    // Reload reads the registers before this cycle's commit lands, so a
    // coincident write only affects the following reload.
    always_comb begin
      cnt_d = cnt_q;
      out_d = out_q;
      if (!operate) begin
        cnt_d = init_count_q;
        out_d = init_state_q;
      end else if (cnt_q > COUNT_WIDTH'(1)) begin
        cnt_d = cnt_q - COUNT_WIDTH'(1);
      end else begin
        out_d = ~out_q;
        cnt_d = out_q ? lo_count_q : hi_count_q;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        init_state_q <= 1'b0;
        init_count_q <= '0;
        hi_count_q   <= '0;
        lo_count_q   <= '0;
        cnt_q        <= '0;
        out_q        <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        out_q <= out_d;
        if (hit && hdr_q[4]) init_state_q <= value_q[0];
        if (hit && hdr_q[5]) init_count_q <= value_q;
        if (hit && hdr_q[6]) hi_count_q   <= value_q;
        if (hit && hdr_q[7]) lo_count_q   <= value_q;
      end
    end
  end

endmodule

// File: tb/tb_cntrl_pulse_sequencer_multi.sv
// Directed bench: 4-channel 32-bit instance (a) and 2-channel 16-bit instance (b)
// sharing clock and reset; all expectations are hand-computed constants.
module tb_cntrl_pulse_sequencer_multi;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;

  logic       op_a = 1'b0, mask_a = 1'b0;
  logic [7:0] data_a = 8'd0;
  logic       ack_a, err_a;
  logic [3:0] out_a;

  logic       op_b = 1'b0, mask_b = 1'b0;
  logic [7:0] data_b = 8'd0;
  logic       ack_b, err_b;
  logic [1:0] out_b;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  cntrl_pulse_sequencer_multi #(.N_CHAN(4), .COUNT_WIDTH(32)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .operate(op_a), .mask_bit(mask_a),
    .cmd_data(data_a), .data_ack(ack_a), .cmd_err(err_a), .out(out_a)
  );

  cntrl_pulse_sequencer_multi #(.N_CHAN(2), .COUNT_WIDTH(16)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .operate(op_b), .mask_bit(mask_b),
    .cmd_data(data_b), .data_ack(ack_b), .cmd_err(err_b), .out(out_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Drives one full command on instance a (sel=0) or b (sel=1); returns at the
  // negedge after the COMMIT cycle.
  task automatic send_cmd(input bit sel, input logic [7:0] hdr, input logic [31:0] value,
                          input string tag);
    int nb;
    int acks;
    logic [31:0] tmp;
    nb   = sel ? 2 : 4;
    acks = 0;
    if (sel) mask_b = 1'b1; else mask_a = 1'b1;
    @(negedge clk);
    if (sel) begin mask_b = 1'b0; data_b = hdr; acks += int'(ack_b); end
    else     begin mask_a = 1'b0; data_a = hdr; acks += int'(ack_a); end
    @(negedge clk);
    for (int k = 0; k < nb; k++) begin
      tmp = value >> (8 * (nb - 1 - k));
      if (sel) begin data_b = tmp[7:0]; acks += int'(ack_b); end
      else     begin data_a = tmp[7:0]; acks += int'(ack_a); end
      @(negedge clk);
    end
    acks += sel ? int'(ack_b) : int'(ack_a);
    @(negedge clk);
    chk({tag, "_acklen"}, acks, nb + 2);
    chk({tag, "_ackoff"}, sel ? ack_b : ack_a, 1'b0);
  endtask

  logic hist [1:16];

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_out", out_a, 4'h0);
    chk("rst_ack", ack_a, 1'b0);
    chk("rst_err", err_a, 1'b0);

    // ch1: hi=3, lo=2, init 0 -> rises after 1 cycle, then 3 high / 2 low
    send_cmd(0, 8'h41, 32'h3, "hi_ch1");
    send_cmd(0, 8'h81, 32'h2, "lo_ch1");
    @(negedge clk);
    op_a = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk($sformatf("ch1_wave%0d", i), out_a[1], ((i - 1) % 5) < 3);
    end
    op_a = 1'b0;
    @(negedge clk);
    chk("stop_out", out_a, 4'h0);

    // broadcast init_state=1
    send_cmd(0, 8'h1F, 32'h1, "bcast");
    chk("bcast_pre", out_a, 4'h0);
    @(negedge clk);
    chk("bcast_post", out_a, 4'hF);

    // illegal index 7: would clear init_state if it wrote anything
    chk("err_before", err_a, 1'b0);
    send_cmd(0, 8'h17, 32'h0, "illegal");
    chk("err_set", err_a, 1'b1);
    @(negedge clk);
    chk("illegal_nowr", out_a, 4'hF);

    send_cmd(0, 8'h10, 32'h0, "ch0_init0");
    @(negedge clk);
    chk("ch0_init0_out", out_a, 4'hE);
    chk("err_sticky", err_a, 1'b1);

    // ch0 hi=8, lo=3; hi rewritten to 2 while the first high phase runs
    send_cmd(0, 8'h40, 32'h8, "hi8_ch0");
    send_cmd(0, 8'h80, 32'h3, "lo3_ch0");
    @(negedge clk);
    op_a = 1'b1;
    fork
      send_cmd(0, 8'h40, 32'h2, "hi2_ch0");
      for (int i = 1; i <= 16; i++) begin
        @(negedge clk);
        hist[i] = out_a[0];
      end
    join
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("hi_rewrite%0d", i), hist[i],
          (i <= 8) || (i == 12) || (i == 13));
    end
    op_a = 1'b0;
    @(negedge clk);
    chk("op_fall_out", out_a, 4'hE);

    // asynchronous reset in the middle of D[1]
    mask_a = 1'b1;
    @(negedge clk);
    mask_a = 1'b0;
    data_a = 8'h5F;
    @(negedge clk);
    data_a = 8'h00;
    @(negedge clk);
    chk("mid_ack", ack_a, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_ack", ack_a, 1'b0);
    chk("midrst_err", err_a, 1'b0);
    chk("midrst_out", out_a, 4'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out", out_a, 4'h0);
    send_cmd(0, 8'h1F, 32'h1, "bcast2");
    @(negedge clk);
    chk("bcast2_post", out_a, 4'hF);
    chk("post_rst_err", err_a, 1'b0);

    // 16-bit instance: init_count ch0 = 0x0003 (second byte is LSB)
    send_cmd(1, 8'h20, 32'h0003, "b_initcnt");
    @(negedge clk);
    op_b = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      case (i)
        1: chk("b_wave1", out_b, 2'b10);
        2: chk("b_wave2", out_b, 2'b00);
        3: chk("b_wave3", out_b, 2'b11);
        4: chk("b_wave4", out_b, 2'b00);
        5: chk("b_wave5", out_b, 2'b11);
        default: chk("b_wave6", out_b, 2'b00);
      endcase
    end
    chk("b_err", err_b, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
